wb_dma_loader: RTL and testbench

- Wishbone master that sits directly upstream of the accelerator's Wishbone slave window.
- Copies a block of 32-bit words from a source address range into a destination range, normally the accelerator SRAM window.
- Optionally then writes an operation code to the accelerator's operation register and polls its status register until the job completes.
- Takes the place of software loops on the management core for load-and-launch sequences.

---
 rtl/wb_dma_loader.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_wb_dma_loader.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_dma_loader.sv
// Purpose: Wishbone master that copies a block of words, then can write an accelerator op register and poll its status.
// Latency: 3 cycles per bus transaction with a 1-cycle-ack slave; done pulses the cycle after the DONE state.
// Backpressure: holds cyc/stb, address and data until ack or err; a stalled slave is abandoned after ACK_TIMEOUT cycles.
module wb_dma_loader #(
    parameter logic [31:0] ADDR_OFFSET    = 32'h3000_0000,
    parameter logic [31:0] OP_REG_OFS     = 32'h0000_0000,
    parameter logic [31:0] STATUS_REG_OFS = 32'h0000_0004,
    parameter int          ACK_TIMEOUT    = 255,
    parameter int          POLL_GAP       = 16,
    parameter int          MAX_POLLS      = 1024
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        start,
    input  logic [31:0] src_addr,
    input  logic [31:0] dst_addr,
    input  logic [8:0]  word_count,
    input  logic        launch_op,
    input  logic [31:0] op_code,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [31:0] result_status,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i
);

    localparam int ACW = $clog2(ACK_TIMEOUT + 1);
    localparam int PGW = $clog2(POLL_GAP + 1);
    localparam int PCW = $clog2(MAX_POLLS + 1);
    localparam logic [ACW-1:0] ACK_LAST  = ACW'(ACK_TIMEOUT - 1);
    localparam logic [PGW-1:0] WAIT_LAST = PGW'(POLL_GAP - 1);
    localparam logic [PCW-1:0] POLL_LIM  = PCW'(MAX_POLLS);
    localparam logic [31:0]    OP_ADR    = ADDR_OFFSET + OP_REG_OFS;
    localparam logic [31:0]    ST_ADR    = ADDR_OFFSET + STATUS_REG_OFS;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_GAP,
        S_OP_WR,
        S_POLL_RD,
        S_POLL_WAIT,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          r_after;      // where GAP hands over once the bus has rested a cycle
    state_t          w_state_nxt;
    state_t          w_after_nxt;

    logic [31:0]     r_src;
    logic [31:0]     r_dst;
    logic [8:0]      r_count;
    logic            r_launch;
    logic [31:0]     r_op;
    logic [8:0]      r_idx;
    logic [31:0]     r_data;
    logic [ACW-1:0]  r_ack_cnt;
    logic [PGW-1:0]  r_wait_cnt;
    logic [PCW-1:0]  r_poll_cnt;
    logic            r_busy;
    logic            r_done;
    logic            r_error;
    logic [31:0]     r_status;

    logic            w_in_bus;
    logic            w_ok;
    logic            w_fail;
    logic            w_accept;
    logic            w_last_word;
    logic            w_not_ready;
    logic [8:0]      w_idx_inc;
    logic [PCW-1:0]  w_poll_inc;
    logic [31:0]     w_ofs;

    assign w_in_bus    = (r_state == S_RD) || (r_state == S_WR) ||
                         (r_state == S_OP_WR) || (r_state == S_POLL_RD);
    // err beats ack; a missing ack on the last allowed wait cycle counts as a failure
    assign w_fail      = w_in_bus && (wbm_err_i || (!wbm_ack_i && (r_ack_cnt == ACK_LAST)));
    assign w_ok        = w_in_bus && wbm_ack_i && !wbm_err_i;
    // r_done is high in the first IDLE cycle after a job, so a start coinciding with done is dropped
    assign w_accept    = (r_state == S_IDLE) && start && !r_done;
    assign w_idx_inc   = r_idx + 9'd1;
    assign w_last_word = (w_idx_inc == r_count);
    assign w_not_ready = (wbm_dat_i == 32'hFFFF_FFFF);
    assign w_poll_inc  = r_poll_cnt + 1'b1;
    assign w_ofs       = {21'd0, r_idx, 2'b00};

    assign busy          = r_busy;
    assign done          = r_done;
    assign error         = r_error;
    assign result_status = r_status;

    // State register
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= S_IDLE;
            r_after <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
            r_after <= w_after_nxt;
        end
    end

    // Next-state decode; every acked transaction rests in GAP except a not-ready poll, whose wait already idles the bus
    always_comb begin
        w_state_nxt = r_state;
        w_after_nxt = r_after;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (word_count == 9'd0) begin
                        w_state_nxt = launch_op ? S_OP_WR : S_DONE;
                    end else begin
                        w_state_nxt = S_RD;
                    end
                end
            end
            S_RD: begin
                if (w_fail) begin
                    w_state_nxt = S_DONE;
                end else if (w_ok) begin
                    w_state_nxt = S_GAP;
                    w_after_nxt = S_WR;
                end
            end
            S_WR: begin
                if (w_fail) begin
                    w_state_nxt = S_DONE;
                end else if (w_ok) begin
                    w_state_nxt = S_GAP;
                    if (w_last_word) begin
                        w_after_nxt = r_launch ? S_OP_WR : S_DONE;
                    end else begin
                        w_after_nxt = S_RD;
                    end
                end
            end
            S_OP_WR: begin
                if (w_fail) begin
                    w_state_nxt = S_DONE;
                end else if (w_ok) begin
                    w_state_nxt = S_GAP;
                    w_after_nxt = S_POLL_RD;
                end
            end
            S_POLL_RD: begin
                if (w_fail) begin
                    w_state_nxt = S_DONE;
                end else if (w_ok) begin
                    if (w_not_ready && (w_poll_inc != POLL_LIM)) begin
                        w_state_nxt = S_POLL_WAIT;
                    end else begin
                        w_state_nxt = S_GAP;
                        w_after_nxt = S_DONE;
                    end
                end
            end
            S_POLL_WAIT: begin
                if (r_wait_cnt == WAIT_LAST) begin
                    w_state_nxt = S_POLL_RD;
                end
            end
            S_GAP:   w_state_nxt = r_after;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Bus drive, decoded from registered state so address and data hold steady until the slave responds
    always_comb begin
        wbm_cyc_o = 1'b0;
        wbm_stb_o = 1'b0;
        wbm_we_o  = 1'b0;
        wbm_sel_o = 4'h0;
        wbm_adr_o = 32'h0;
        wbm_dat_o = 32'h0;
        if (w_in_bus) begin
            wbm_cyc_o = 1'b1;
            wbm_stb_o = 1'b1;
            wbm_sel_o = 4'hF;
        end
        case (r_state)
            S_RD:      wbm_adr_o = r_src + w_ofs;
            S_WR: begin
                wbm_we_o  = 1'b1;
                wbm_adr_o = r_dst + w_ofs;
                wbm_dat_o = r_data;
            end
            S_OP_WR: begin
                wbm_we_o  = 1'b1;
                wbm_adr_o = OP_ADR;
                wbm_dat_o = r_op;
            end
            S_POLL_RD: wbm_adr_o = ST_ADR;
            default: ;
        endcase
    end

    // Ack wait counter restarts with each request; poll gap counter runs only while waiting between polls
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_ack_cnt  <= '0;
            r_wait_cnt <= '0;
        end else begin
            if (!w_in_bus || wbm_ack_i || wbm_err_i) begin
                r_ack_cnt <= '0;
            end else begin
                r_ack_cnt <= r_ack_cnt + 1'b1;
            end
            if (r_state == S_POLL_WAIT) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end else begin
                r_wait_cnt <= '0;
            end
        end
    end

    // Job parameters, copy index, captured read data and the user-visible status flags
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_src      <= '0;
            r_dst      <= '0;
            r_count    <= '0;
            r_launch   <= 1'b0;
            r_op       <= '0;
            r_idx      <= '0;
            r_data     <= '0;
            r_poll_cnt <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_status   <= '0;
        end else begin
            r_done <= (r_state == S_DONE);
            if (r_state == S_DONE) begin
                r_busy <= 1'b0;
            end
            if (w_accept) begin
                r_src    <= src_addr;
                r_dst    <= dst_addr;
                r_count  <= word_count;
                r_launch <= launch_op;
                r_op     <= op_code;
                r_idx    <= '0;
                r_error  <= 1'b0;
                r_busy   <= 1'b1;
            end
            if (w_fail) begin
                r_error <= 1'b1;
            end
            if (w_ok) begin
                case (r_state)
                    S_RD:    r_data     <= wbm_dat_i;
                    S_WR:    r_idx      <= w_idx_inc;
                    S_OP_WR: r_poll_cnt <= '0;
                    S_POLL_RD: begin
                        if (w_not_ready) begin
                            r_poll_cnt <= w_poll_inc;
                            if (w_poll_inc == POLL_LIM) begin
                                r_error <= 1'b1;
                            end
                        end else begin
                            r_status <= wbm_dat_i;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_wb_dma_loader.sv
// Purpose: self-checking bench for wb_dma_loader against a transaction-level reference of the copy/launch/poll job.
// Latency: expected job time is derived from 3 cycles per transaction plus the poll gap.
// Backpressure: the slave model can withhold ack on a chosen read or raise err on the op write.
module tb_wb_dma_loader;

    localparam logic [31:0] OP_ADR = 32'h3000_0000;
    localparam logic [31:0] ST_ADR = 32'h3000_0004;
    localparam int          ACK_TO = 255;
    localparam int          PGAP   = 16;
    localparam int          MAXP   = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] src_addr = '0;
    logic [31:0] dst_addr = '0;
    logic [8:0]  word_count = '0;
    logic        launch_op = 1'b0;
    logic [31:0] op_code = '0;
    logic        busy, done, error;
    logic [31:0] result_status;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o, wbm_dat_o;
    logic [31:0] wbm_dat_i = '0;
    logic        wbm_ack_i = 1'b0;
    logic        wbm_err_i = 1'b0;

    always #5 clk = ~clk;

    wb_dma_loader dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .start(start),
        .src_addr(src_addr), .dst_addr(dst_addr), .word_count(word_count),
        .launch_op(launch_op), .op_code(op_code),
        .busy(busy), .done(done), .error(error), .result_status(result_status),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
        .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i)
    );

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        int          t_start;
        int          t_ack;
    } txn_t;

    txn_t        obs_q[$];
    txn_t        exp_q[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc_n = 0;
    logic [31:0] exp_status = '0;

    // slave model state and knobs
    int          stb_age = 0;
    int          last_stb_len = 0;
    int          t_first = 0;
    int          bus_cycles = 0;
    int          done_cnt = 0;
    int          read_idx = 0;
    int          stall_read = -1;
    bit          err_op = 1'b0;
    bit          stalled = 1'b0;
    int          nr_left = 0;
    logic [31:0] st_val = '0;

    task automatic check_val(input string tag, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    always @(posedge clk) cyc_n++;

    // Wishbone slave: ack arrives in the second strobe cycle, recorded as one completed transaction
    always @(negedge clk) begin
        txn_t        t;
        logic [31:0] rd;
        if (done) done_cnt++;
        if (wbm_cyc_o) bus_cycles++;
        if (wbm_cyc_o && wbm_stb_o) begin
            if (stb_age == 0) begin
                t_first = cyc_n;
                stalled = 1'b0;
                if (!wbm_we_o && wbm_adr_o != ST_ADR) begin
                    stalled = (read_idx == stall_read);
                    read_idx++;
                end
                if (err_op && wbm_we_o && wbm_adr_o == OP_ADR) begin
                    wbm_err_i = 1'b1;
                    t = '{1'b1, wbm_adr_o, wbm_dat_o, t_first, cyc_n};
                    obs_q.push_back(t);
                end
            end else if (!wbm_ack_i && !wbm_err_i && !stalled) begin
                if (wbm_we_o) begin
                    rd = wbm_dat_o;
                end else if (wbm_adr_o == ST_ADR) begin
                    if (nr_left > 0) begin
                        rd = 32'hFFFF_FFFF;
                        nr_left--;
                    end else begin
                        rd = st_val;
                    end
                    wbm_dat_i = rd;
                end else begin
                    rd = mem_val(wbm_adr_o);
                    wbm_dat_i = rd;
                end
                wbm_ack_i = 1'b1;
                t = '{wbm_we_o, wbm_adr_o, rd, t_first, cyc_n};
                obs_q.push_back(t);
            end
            stb_age++;
        end else begin
            if (stb_age != 0) last_stb_len = stb_age;
            stb_age   = 0;
            wbm_ack_i = 1'b0;
            wbm_err_i = 1'b0;
        end
    end

    // Reference job: the bus transactions a job must produce, its outcome and its start-to-done time
    task automatic build_exp(input logic [31:0] src, input logic [31:0] dst, input int cnt, input logic l,
                             input logic [31:0] op, input int nr, input logic [31:0] st, input int stall,
                             input bit eop, output bit e_err, output int e_lat, output bit st_upd);
        txn_t t;
        int   n_eff;
        exp_q.delete();
        e_err  = 1'b0;
        st_upd = 1'b0;
        t.t_start = 0;
        t.t_ack   = 0;
        for (int i = 0; i < cnt; i++) begin
            if (i == stall) begin
                e_err = 1'b1;
                break;
            end
            t.we = 1'b0; t.adr = src + 32'(4 * i); t.dat = mem_val(src + 32'(4 * i));
            exp_q.push_back(t);
            t.we = 1'b1; t.adr = dst + 32'(4 * i);
            exp_q.push_back(t);
        end
        if (l && !e_err) begin
            t.we = 1'b1; t.adr = OP_ADR; t.dat = op;
            exp_q.push_back(t);
            if (eop) begin
                e_err = 1'b1;
            end else begin
                n_eff = (nr >= MAXP) ? MAXP : nr;
                for (int k = 0; k < n_eff; k++) begin
                    t.we = 1'b0; t.adr = ST_ADR; t.dat = 32'hFFFF_FFFF;
                    exp_q.push_back(t);
                end
                if (nr < MAXP) begin
                    t.we = 1'b0; t.adr = ST_ADR; t.dat = st;
                    exp_q.push_back(t);
                    st_upd = 1'b1;
                end else begin
                    e_err = 1'b1;
                end
            end
        end
        if (stall >= 0 || eop) e_lat = -1;
        else if (!l) e_lat = 6 * cnt + 2;
        else e_lat = 6 * cnt + 18 * ((nr >= MAXP) ? MAXP - 1 : nr) + 8;
    endtask

    task automatic run_job(input string tag, input logic [31:0] src, input logic [31:0] dst, input int cnt,
                           input logic l, input logic [31:0] op, input int nr, input logic [31:0] st,
                           input int stall, input bit eop);
        bit e_err, st_upd;
        int e_lat, t0, guard, n;
        build_exp(src, dst, cnt, l, op, nr, st, stall, eop, e_err, e_lat, st_upd);
        obs_q.delete();
        read_idx = 0; stall_read = stall; err_op = eop; nr_left = nr; st_val = st;
        @(negedge clk);
        done_cnt   = 0;
        src_addr   = src; dst_addr = dst; word_count = 9'(cnt);
        launch_op  = l;   op_code  = op;  start = 1'b1;
        t0 = cyc_n;
        @(negedge clk);
        start      = 1'b0;
        src_addr   = $urandom; dst_addr = $urandom; word_count = 9'($urandom);
        launch_op  = 1'($urandom); op_code = $urandom;
        check_val($sformatf("%s_busy_c1", tag), busy, 1);
        check_val($sformatf("%s_err_clr", tag), error, 0);
        guard = 0;
        while (!done && guard < 25000) begin
            @(negedge clk);
            guard++;
        end
        check_val($sformatf("%s_done_seen", tag), done, 1);
        check_val($sformatf("%s_busy_at_done", tag), busy, 0);
        if (e_lat >= 0) check_val($sformatf("%s_latency", tag), cyc_n - t0, e_lat);
        repeat (3) @(negedge clk);
        if (st_upd) exp_status = st;
        check_val($sformatf("%s_done_cnt", tag), done_cnt, 1);
        check_val($sformatf("%s_error", tag), error, e_err);
        check_val($sformatf("%s_status", tag), result_status, exp_status);
        check_val($sformatf("%s_ntxn", tag), obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check_val($sformatf("%s_txn%0d", tag, i), {7'd0, obs_q[i].we, obs_q[i].adr, obs_q[i].dat},
                      {7'd0, exp_q[i].we, exp_q[i].adr, exp_q[i].dat});
        end
    endtask

    initial begin
        int          bc, guard, n;
        bit          e_err, st_upd;
        int          e_lat;
        logic [31:0] s, d, st;
        int          c, nr;
        logic        l;

        // reset state
        repeat (3) @(negedge clk);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_error", error, 0);
        check_val("rst_status", result_status, 0);
        check_val("rst_bus", {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o}, 0);
        rst = 1'b0;
        @(negedge clk);

        run_job("copy4", 32'h0000_1000, 32'h3000_0100, 4, 1'b0, 32'h0, 0, 32'h0, -1, 1'b0);

        run_job("launch256", 32'h0000_2000, 32'h3000_0400, 256, 1'b1, 32'h1, 3, 32'h0, -1, 1'b0);
        n = 0;
        for (int j = 1; j < obs_q.size(); j++) begin
            if (obs_q[j].adr == ST_ADR && obs_q[j-1].adr == ST_ADR) begin
                check_val("poll_idle", obs_q[j].t_start - obs_q[j-1].t_ack - 1, PGAP);
                n++;
            end
        end
        check_val("poll_pairs", n, 3);

        run_job("timeout", 32'h0000_4000, 32'h3000_0600, 4, 1'b0, 32'h0, 0, 32'h0, 1, 1'b0);
        check_val("timeout_stb_len", last_stb_len, ACK_TO);

        run_job("operr", 32'h0000_0100, 32'h3000_0800, 2, 1'b1, 32'h0000_ABCD, 0, 32'h5, -1, 1'b1);
        run_job("clean", 32'h0000_0200, 32'h3000_0900, 3, 1'b1, 32'h0000_0002, 1, 32'h0000_0077, -1, 1'b0);

        run_job("zero", 32'h0000_0300, 32'h3000_0A00, 0, 1'b0, 32'h0, 0, 32'h0, -1, 1'b0);

        // a start coinciding with the done pulse is dropped
        @(negedge clk);
        word_count = 9'd0; launch_op = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check_val("done_cycle_pulse", done, 1);
        word_count = 9'd4; src_addr = 32'h0000_0400; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bc = bus_cycles;
        repeat (30) @(negedge clk);
        check_val("start_in_done_bus", bus_cycles - bc, 0);
        check_val("start_in_done_busy", busy, 0);

        // randomized jobs, first one wrapping the source address past 2^32
        for (int k = 0; k < 8; k++) begin
            s  = (k == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0FFF_FFFC);
            d  = 32'h3000_1000 + ($urandom & 32'h0000_0FFC);
            c  = $urandom_range(0, 12);
            l  = 1'($urandom_range(0, 1));
            nr = $urandom_range(0, 3);
            st = $urandom & 32'h7FFF_FFFF;
            run_job($sformatf("rnd%0d", k), s, d, (k == 0) ? 4 : c, l, $urandom, nr, st, -1, 1'b0);
        end

        run_job("maxpoll", 32'h0000_0010, 32'h3000_0100, 1, 1'b1, 32'h5, 100000, 32'h0, -1, 1'b0);

        // re-pulse while busy is ignored; reset during a write ends all bus activity
        build_exp(32'h0000_5000, 32'h3000_0200, 8, 1'b0, 32'h0, 0, 32'h0, -1, 1'b0, e_err, e_lat, st_upd);
        obs_q.delete();
        read_idx = 0; stall_read = -1; err_op = 1'b0;
        @(negedge clk);
        done_cnt = 0;
        src_addr = 32'h0000_5000; dst_addr = 32'h3000_0200; word_count = 9'd8; launch_op = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        src_addr = 32'h0000_9000; dst_addr = 32'h3000_0F00; word_count = 9'd3; launch_op = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        guard = 0;
        while (!(wbm_stb_o && wbm_we_o && wbm_adr_o == 32'h3000_0208) && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        check_val("rst_wr_reached", guard < 500, 1);
        rst = 1'b1;
        @(negedge clk);
        check_val("rst_mid_cyc_stb", {wbm_cyc_o, wbm_stb_o}, 0);
        check_val("rst_mid_busy", busy, 0);
        check_val("rst_mid_status", result_status, 0);
        rst = 1'b0;
        exp_status = '0;
        bc = bus_cycles;
        repeat (40) @(negedge clk);
        check_val("rst_no_bus", bus_cycles - bc, 0);
        check_val("rst_no_done", done_cnt, 0);
        check_val("rst_ntxn_ok", (obs_q.size() >= 5) && (obs_q.size() <= 6), 1);
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check_val($sformatf("rst_txn%0d", i), {7'd0, obs_q[i].we, obs_q[i].adr, obs_q[i].dat},
                      {7'd0, exp_q[i].we, exp_q[i].adr, exp_q[i].dat});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
